gpio_debounce: RTL and testbench
================================

# gpio_debounce

Input conditioning stage directly upstream of the top-level control core's `gpio1`/`gpio2` inputs. Synchronises the two raw GPIO pins, debounces each with a per-channel counter FSM, and drives clean levels into the control core. Also latches rise/fall events in a small bus-mapped register bank so firmware can poll for edges without sampling the level continuously.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, 18000: consecutive cycles a changed synced input must hold before the stable output follows; legal range 2..65535 (1 ms at 18 MHz).
- `CNT_WIDTH`, 16: counter width; must satisfy 2^CNT_WIDTH > DEBOUNCE_CYCLES.

Ports:
- `clk` input 1: system clock; single clock domain.
- `reset` input 1: asynchronous, active-high reset.
- `gpio1_in` input 1: raw pin, asynchronous.
- `gpio2_in` input 1: raw pin, asynchronous.
- `gpio1_db` output 1: debounced level; feeds control core `gpio1`.
- `gpio2_db` output 1: debounced level; feeds control core `gpio2`.
- `cs` input 1: bus chip select.
- `we` input 1: bus write enable.
- `address` input 8: word address.
- `write_data` input 32: bus write data.
- `read_data` output 32: bus read data; combinational.
- `ready` output 1: bus ready; combinational.

## Operation
- Per channel, the pin passes through a 2-flop synchroniser (`sync[1:0]`). `sync[1]` is the FSM input `s`.
- Per-channel FSM states: `ST_LOW`, `ST_WAIT_HIGH`, `ST_HIGH`, `ST_WAIT_LOW`. The stable output is 1 in `ST_HIGH` and `ST_WAIT_LOW`, and 0 otherwise.
- In `ST_LOW` with `s`=1: go to `ST_WAIT_HIGH` and set cnt=1.
- In `ST_WAIT_HIGH`:
  - `s`=0: return to `ST_LOW` and set cnt=0.
  - `s`=1 and cnt==DEBOUNCE_CYCLES-1: go to `ST_HIGH`, set cnt=0, and pulse `rise`.
  - `s`=1 otherwise: cnt+1.
- `ST_HIGH` and `ST_WAIT_LOW` mirror the above with polarity inverted and pulse `fall`.
- Any glitch shorter than DEBOUNCE_CYCLES cycles never changes the output. The counter never wraps.
- Register map (reads return 0 for unmapped addresses):
  - 0x00 NAME0 = 32'h67646231 ("gdb1"), read-only.
  - 0x02 VERSION = 32'h00000001, read-only.
  - 0x08 STATUS = {30'h0, gpio2_db, gpio1_db}, read-only.
  - 0x09 EVENT = {28'h0, fall2, rise2, fall1, rise1}; sticky. A write clears each bit whose `write_data` bit is 1 (write-1-to-clear).
  - 0x0a MASK = 4-bit enable per EVENT bit, read/write, reset 4'hf. A masked-off event bit is not set, but an already-set bit remains until cleared.
- If a set pulse and a W1C land on the same bit in the same cycle, the set wins.
- `ready` = `cs`. `read_data` = 0 when `cs`=0 or `we`=1.

## Timing
- Reset values: `gpio1_db`=`gpio2_db`=0, FSMs in `ST_LOW`, cnt=0, sync=0, EVENT=0, MASK=4'hf. `read_data` and `ready` are combinational, so both are 0 whenever `cs`=0.
- Latency from pin edge to output change: 2 (synchroniser) + DEBOUNCE_CYCLES cycles.
- An EVENT bit is readable on the bus the cycle after the output changes.
- Reset asserted mid-count returns everything to reset values immediately, without waiting for a clock. The first clock edge after deassertion restarts synchronisation.
- Writes take effect at the clock edge where `cs`&`we` are high.
- Reads are single-cycle and zero-wait.

## Configuration
- `GPIO_DEBOUNCE_EVENT_EN` defined: the EVENT and MASK registers and the edge pulses are present.
- Undefined: EVENT and MASK read 0, writes to them are ignored, and no event flops are synthesised. STATUS, NAME0, VERSION and the debounced outputs are unchanged.

## Structure
- Shared package `gpio_debounce_pkg` holds:
  - address localparams (ADDR_NAME0, ADDR_VERSION, ADDR_STATUS, ADDR_EVENT, ADDR_MASK);
  - the NAME0 and VERSION constants;
  - the 2-bit FSM state encoding.
- Sub-module `debounce_channel` contains the synchroniser, counter and FSM for one pin. Outputs: `level`, `rise`, `fall`.
- The top module instantiates `debounce_channel` twice and adds the register bank.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4.
- Reset with pins low: `gpio*_db`=0, STATUS reads 0, MASK reads 0xf, NAME0 reads 0x67646231.
- Hold `gpio1_in`=1: `gpio1_db` rises exactly 6 cycles after the pin edge. EVENT then reads 0x1. Writing 0x1 to 0x09 makes EVENT read 0x0.
- Pulse `gpio2_in` high for 3 cycles, then low: `gpio2_db` stays 0 and EVENT stays 0.
- With MASK written to 0x0, toggle `gpio1_in` high then low, each held for 10 cycles: STATUS follows the pin, EVENT stays 0.
- Issue a W1C of 0x1 in the same cycle as a new rise1 pulse: EVENT bit0 reads 1 afterwards.
- Assert `reset` asynchronously while `gpio1_db`=1 and a falling count is in progress: `gpio1_db` goes to 0 before the next clock edge. After deassertion, with the pin still high, the output returns to 1 after 6 cycles.

Source files
------------

// File: rtl/gpio_debounce_pkg.sv
// rtl/gpio_debounce_pkg.sv - shared constants and types for the GPIO debounce block
//
// Purpose: register addresses, identification constants and the per-channel
//          debounce state encoding used by gpio_debounce and debounce_channel.
// Ports:   none (package).
// Config:  GPIO_DEBOUNCE_EVENT_EN selects the event/mask registers in the top.
package gpio_debounce_pkg;

  localparam logic [7:0] ADDR_NAME0   = 8'h00;
  localparam logic [7:0] ADDR_VERSION = 8'h02;
  localparam logic [7:0] ADDR_STATUS  = 8'h08;
  localparam logic [7:0] ADDR_EVENT   = 8'h09;
  localparam logic [7:0] ADDR_MASK    = 8'h0a;

  localparam logic [31:0] NAME0_VALUE   = 32'h67646231;  // "gdb1"
  localparam logic [31:0] VERSION_VALUE = 32'h00000001;

  typedef enum logic [1:0] {
    ST_LOW       = 2'd0,
    ST_WAIT_HIGH = 2'd1,
    ST_HIGH      = 2'd2,
    ST_WAIT_LOW  = 2'd3
  } db_state_t;

endpackage

// File: rtl/debounce_channel.sv
// rtl/debounce_channel.sv - synchroniser, counter and debounce FSM for one pin
//
// Purpose: brings one asynchronous pin into the clk domain through two flops and
//          only lets the stable level follow after the synced value has held a
//          new value for DEBOUNCE_CYCLES consecutive cycles.
// Ports:
//   clk    - system clock
//   reset  - asynchronous, active-high reset
//   pin    - raw asynchronous input
//   level  - debounced level (registered)
//   rise   - one-cycle pulse when level goes 0->1 (registered)
//   fall   - one-cycle pulse when level goes 1->0 (registered)
module debounce_channel #(
  parameter int DEBOUNCE_CYCLES = 18000,
  parameter int CNT_WIDTH       = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  import gpio_debounce_pkg::*;

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  logic [1:0]           r_sync;
  db_state_t            r_state;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic                 r_level;
  logic                 r_rise;
  logic                 r_fall;
  logic                 w_s;

  assign w_s = r_sync[1];

  // The cycle that leaves a steady state counts as the first of the hold, so
  // the transition fires when cnt reaches DEBOUNCE_CYCLES-1 with s still held.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync  <= 2'b00;
      r_state <= ST_LOW;
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], pin};
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      case (r_state)
        ST_LOW: begin
          if (w_s) begin
            r_state <= ST_WAIT_HIGH;
            r_cnt   <= CNT_ONE;
          end
        end
        ST_WAIT_HIGH: begin
          if (!w_s) begin
            r_state <= ST_LOW;
            r_cnt   <= '0;
          end else if (r_cnt == CNT_LAST) begin
            r_state <= ST_HIGH;
            r_cnt   <= '0;
            r_level <= 1'b1;
            r_rise  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        ST_HIGH: begin
          if (!w_s) begin
            r_state <= ST_WAIT_LOW;
            r_cnt   <= CNT_ONE;
          end
        end
        ST_WAIT_LOW: begin
          if (w_s) begin
            r_state <= ST_HIGH;
            r_cnt   <= '0;
          end else if (r_cnt == CNT_LAST) begin
            r_state <= ST_LOW;
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_fall  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        default: begin
          r_state <= ST_LOW;
          r_cnt   <= '0;
          r_level <= 1'b0;
        end
      endcase
    end
  end

  assign level = r_level;
  assign rise  = r_rise;
  assign fall  = r_fall;

endmodule

// File: rtl/gpio_debounce.sv
// rtl/gpio_debounce.sv - two-channel GPIO debouncer with bus-mapped status/event registers
//
// Purpose: debounces gpio1_in/gpio2_in for the control core and exposes levels,
//          sticky edge events and an event mask on a simple word-addressed bus.
// Config:  define GPIO_DEBOUNCE_EVENT_EN to build the EVENT/MASK registers;
//          otherwise they read 0 and writes to them are ignored.
// Ports:
//   clk, reset            - clock, asynchronous active-high reset
//   gpio1_in, gpio2_in    - raw asynchronous pins
//   gpio1_db, gpio2_db    - debounced levels
//   cs, we, address       - bus select, write enable, word address
//   write_data            - bus write data
//   read_data, ready      - combinational read data and ready
module gpio_debounce #(
  parameter int DEBOUNCE_CYCLES = 18000,
  parameter int CNT_WIDTH       = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        gpio1_in,
  input  logic        gpio2_in,
  output logic        gpio1_db,
  output logic        gpio2_db,
  input  logic        cs,
  input  logic        we,
  input  logic [7:0]  address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready
);

  import gpio_debounce_pkg::*;

  logic       w_level1;
  logic       w_level2;
  logic       w_rise1;
  logic       w_fall1;
  logic       w_rise2;
  logic       w_fall2;
  logic [3:0] w_event_rd;
  logic [3:0] w_mask_rd;
  logic       w_unused;
  logic [31:0] w_rdata;

  debounce_channel #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_WIDTH       (CNT_WIDTH)
  ) u_ch1 (
    .clk   (clk),
    .reset (reset),
    .pin   (gpio1_in),
    .level (w_level1),
    .rise  (w_rise1),
    .fall  (w_fall1)
  );

  debounce_channel #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_WIDTH       (CNT_WIDTH)
  ) u_ch2 (
    .clk   (clk),
    .reset (reset),
    .pin   (gpio2_in),
    .level (w_level2),
    .rise  (w_rise2),
    .fall  (w_fall2)
  );

  assign gpio1_db = w_level1;
  assign gpio2_db = w_level2;

`ifdef GPIO_DEBOUNCE_EVENT_EN
  logic [3:0] r_event;
  logic [3:0] r_mask;
  logic       w_wr;
  logic [3:0] w_clr;
  logic [3:0] w_set;

  assign w_wr  = cs & we;
  assign w_clr = (w_wr && (address == ADDR_EVENT)) ? write_data[3:0] : 4'h0;
  assign w_set = {w_fall2, w_rise2, w_fall1, w_rise1} & r_mask;

  // Set is OR-ed in after the clear so a same-cycle pulse beats a W1C.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_event <= 4'h0;
      r_mask  <= 4'hf;
    end else begin
      r_event <= (r_event & ~w_clr) | w_set;
      if (w_wr && (address == ADDR_MASK)) begin
        r_mask <= write_data[3:0];
      end
    end
  end

  assign w_event_rd = r_event;
  assign w_mask_rd  = r_mask;
  assign w_unused   = ^write_data[31:4];
`else
  assign w_event_rd = 4'h0;
  assign w_mask_rd  = 4'h0;
  assign w_unused   = ^{write_data, w_rise1, w_fall1, w_rise2, w_fall2};
`endif

  always_comb begin
    w_rdata = 32'h0;
    case (address)
      ADDR_NAME0:   w_rdata = NAME0_VALUE;
      ADDR_VERSION: w_rdata = VERSION_VALUE;
      ADDR_STATUS:  w_rdata = {30'h0, w_level2, w_level1};
      ADDR_EVENT:   w_rdata = {28'h0, w_event_rd};
      ADDR_MASK:    w_rdata = {28'h0, w_mask_rd};
      default:      w_rdata = 32'h0;
    endcase
  end

  assign read_data = (cs && !we) ? w_rdata : 32'h0;
  assign ready     = cs;

endmodule

// File: tb/tb_gpio_debounce.sv
// tb/tb_gpio_debounce.sv - self-checking bench for gpio_debounce
module tb_gpio_debounce;

  localparam int D = 4;
`ifdef GPIO_DEBOUNCE_EVENT_EN
  localparam bit EV_EN = 1'b1;
`else
  localparam bit EV_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        gpio1_in = 1'b0;
  logic        gpio2_in = 1'b0;
  logic        gpio1_db;
  logic        gpio2_db;
  logic        cs = 1'b0;
  logic        we = 1'b0;
  logic [7:0]  address = 8'h0;
  logic [31:0] write_data = 32'h0;
  logic [31:0] read_data;
  logic        ready;

  int total = 0;
  int bad = 0;

  gpio_debounce #(.DEBOUNCE_CYCLES(D), .CNT_WIDTH(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .gpio1_in   (gpio1_in),
    .gpio2_in   (gpio2_in),
    .gpio1_db   (gpio1_db),
    .gpio2_db   (gpio2_db),
    .cs         (cs),
    .we         (we),
    .address    (address),
    .write_data (write_data),
    .read_data  (read_data),
    .ready      (ready)
  );

  always #5 clk = ~clk;

  // Reference model: a synced pin that differs from the output for D
  // consecutive clocks flips the output; events land one clock later.
  bit [1:0] m_s0 = 2'b00;
  bit [1:0] m_s1 = 2'b00;
  bit [1:0] m_out = 2'b00;
  int       m_run [2] = '{0, 0};
  bit [3:0] m_pend = 4'h0;
  bit [3:0] m_event = 4'h0;
  bit [3:0] m_mask = 4'hf;
  bit [3:0] m_clr;
  bit [3:0] m_pend_nxt;
  bit [1:0] m_pins;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_s0 = 2'b00; m_s1 = 2'b00; m_out = 2'b00;
      m_run[0] = 0; m_run[1] = 0;
      m_pend = 4'h0; m_event = 4'h0; m_mask = 4'hf;
    end else begin
      m_pins = {gpio2_in, gpio1_in};
      m_clr = (cs && we && address == 8'h09) ? write_data[3:0] : 4'h0;
      m_event = (m_event & ~m_clr) | (m_pend & m_mask);
      if (cs && we && address == 8'h0a) m_mask = write_data[3:0];
      m_pend_nxt = 4'h0;
      for (int ch = 0; ch < 2; ch++) begin
        if (m_s1[ch] != m_out[ch]) begin
          m_run[ch] = m_run[ch] + 1;
          if (m_run[ch] == D) begin
            m_out[ch] = ~m_out[ch];
            m_run[ch] = 0;
            m_pend_nxt[ch * 2 + (m_out[ch] ? 0 : 1)] = 1'b1;
          end
        end else begin
          m_run[ch] = 0;
        end
      end
      m_pend = m_pend_nxt;
      m_s1 = m_s0;
      m_s0 = m_pins;
    end
  end

  function automatic logic [31:0] exp_read(input logic [7:0] a);
    case (a)
      8'h00:   return 32'h67646231;
      8'h02:   return 32'h00000001;
      8'h08:   return {30'h0, m_out[1], m_out[0]};
      8'h09:   return EV_EN ? {28'h0, m_event} : 32'h0;
      8'h0a:   return EV_EN ? {28'h0, m_mask} : 32'h0;
      default: return 32'h0;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_read(input logic [7:0] a, output logic [31:0] d);
    @(negedge clk);
    cs = 1'b1; we = 1'b0; address = a;
    #1;
    d = read_data;
    cs = 1'b0; address = 8'h0;
    #1;
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
    cs = 1'b1; we = 1'b1; address = a; write_data = d;
    tick();
    cs = 1'b0; we = 1'b0; address = 8'h0; write_data = 32'h0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    #2 reset = 1'b1;
    #2;
    total++;
    if (gpio1_db !== 1'b0 || gpio2_db !== 1'b0) begin
      bad++; $display("FAIL reset_db got=%b%b exp=00", gpio2_db, gpio1_db);
    end
    total++;
    if (ready !== 1'b0 || read_data !== 32'h0) begin
      bad++; $display("FAIL idle_bus got=%b/%h exp=0/0", ready, read_data);
    end
    @(negedge clk) reset = 1'b0;
    bus_read(8'h08, d);
    total++;
    if (d !== 32'h0) begin bad++; $display("FAIL reset_status got=%h exp=0", d); end
    bus_read(8'h0a, d);
    total++;
    if (d !== (EV_EN ? 32'hf : 32'h0)) begin
      bad++; $display("FAIL reset_mask got=%h exp=%h", d, EV_EN ? 32'hf : 32'h0);
    end
    bus_read(8'h00, d);
    total++;
    if (d !== 32'h67646231) begin bad++; $display("FAIL name0 got=%h exp=67646231", d); end
    bus_read(8'h02, d);
    total++;
    if (d !== 32'h1) begin bad++; $display("FAIL version got=%h exp=1", d); end
  endtask

  task automatic test_rise();
    logic [31:0] d;
    tick();
    gpio1_in = 1'b1;
    repeat (5) tick();
    total++;
    if (gpio1_db !== 1'b0) begin bad++; $display("FAIL rise_early got=%b exp=0", gpio1_db); end
    tick();
    total++;
    if (gpio1_db !== 1'b1) begin bad++; $display("FAIL rise_at6 got=%b exp=1", gpio1_db); end
    tick();
    bus_read(8'h09, d);
    total++;
    if (d !== (EV_EN ? 32'h1 : 32'h0)) begin
      bad++; $display("FAIL rise_event got=%h exp=%h", d, EV_EN ? 32'h1 : 32'h0);
    end
    tick();
    bus_write(8'h09, 32'h1);
    bus_read(8'h09, d);
    total++;
    if (d !== 32'h0) begin bad++; $display("FAIL w1c_clear got=%h exp=0", d); end
  endtask

  task automatic test_glitch();
    logic [31:0] d;
    tick();
    gpio2_in = 1'b1;
    repeat (3) tick();
    gpio2_in = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      total++;
      if (gpio2_db !== 1'b0) begin bad++; $display("FAIL glitch_db cyc=%0d got=%b exp=0", i, gpio2_db); end
    end
    bus_read(8'h09, d);
    total++;
    if (d !== 32'h0) begin bad++; $display("FAIL glitch_event got=%h exp=0", d); end
  endtask

  task automatic test_mask();
    logic [31:0] d;
    bit lvl;
    tick();
    bus_write(8'h0a, 32'h0);
    for (int k = 0; k < 3; k++) begin
      lvl = (k == 1);
      gpio1_in = lvl;
      repeat (10) tick();
      bus_read(8'h08, d);
      total++;
      if (d !== {31'h0, lvl}) begin bad++; $display("FAIL mask_status step=%0d got=%h exp=%h", k, d, {31'h0, lvl}); end
      bus_read(8'h09, d);
      total++;
      if (d !== 32'h0) begin bad++; $display("FAIL mask_event step=%0d got=%h exp=0", k, d); end
      tick();
    end
  endtask

  task automatic test_collision();
    logic [31:0] d;
    bus_write(8'h0a, 32'hf);
    bus_write(8'h09, 32'hf);
    gpio1_in = 1'b1;
    repeat (6) tick();
    total++;
    if (gpio1_db !== 1'b1) begin bad++; $display("FAIL coll_db got=%b exp=1", gpio1_db); end
    bus_write(8'h09, 32'h1);
    bus_read(8'h09, d);
    total++;
    if (d !== (EV_EN ? 32'h1 : 32'h0)) begin
      bad++; $display("FAIL coll_set_wins got=%h exp=%h", d, EV_EN ? 32'h1 : 32'h0);
    end
  endtask

  task automatic test_async_reset();
    logic [31:0] d;
    tick();
    gpio1_in = 1'b0;
    repeat (4) tick();
    gpio1_in = 1'b1;
    #2 reset = 1'b1;
    #1;
    total++;
    if (gpio1_db !== 1'b0) begin bad++; $display("FAIL async_reset_db got=%b exp=0", gpio1_db); end
    bus_read(8'h0a, d);
    total++;
    if (d !== (EV_EN ? 32'hf : 32'h0)) begin bad++; $display("FAIL async_reset_mask got=%h", d); end
    reset = 1'b0;
    repeat (5) tick();
    total++;
    if (gpio1_db !== 1'b0) begin bad++; $display("FAIL post_reset_early got=%b exp=0", gpio1_db); end
    tick();
    total++;
    if (gpio1_db !== 1'b1) begin bad++; $display("FAIL post_reset_at6 got=%b exp=1", gpio1_db); end
  endtask

  task automatic test_random();
    logic [7:0] addrs [7] = '{8'h00, 8'h02, 8'h08, 8'h09, 8'h0a, 8'h01, 8'h33};
    int h1, h2;
    logic [31:0] e;
    h1 = 1; h2 = 1;
    for (int i = 0; i < 400; i++) begin
      tick();
      total++;
      if (gpio1_db !== m_out[0] || gpio2_db !== m_out[1]) begin
        bad++; $display("FAIL rnd_db cyc=%0d got=%b%b exp=%b%b", i, gpio2_db, gpio1_db, m_out[1], m_out[0]);
      end
      cs = 1'b1; we = 1'b0; address = addrs[$urandom_range(0, 6)];
      #1;
      e = exp_read(address);
      total++;
      if (read_data !== e || ready !== 1'b1) begin
        bad++; $display("FAIL rnd_read cyc=%0d addr=%h got=%h exp=%h", i, address, read_data, e);
      end
      h1--; h2--;
      if (h1 == 0) begin gpio1_in = ~gpio1_in; h1 = $urandom_range(1, 8); end
      if (h2 == 0) begin gpio2_in = ~gpio2_in; h2 = $urandom_range(1, 8); end
      if ($urandom_range(0, 15) == 0) begin
        we = 1'b1; address = 8'h0a; write_data = $urandom;
      end else if ($urandom_range(0, 3) == 0) begin
        we = 1'b1; address = 8'h09; write_data = $urandom;
      end else begin
        cs = 1'b0; we = 1'b0; address = 8'h0; write_data = 32'h0;
      end
    end
    tick();
    cs = 1'b0; we = 1'b0; address = 8'h0; write_data = 32'h0;
  endtask

  initial begin
    test_reset();
    test_rise();
    test_glitch();
    test_mask();
    test_collision();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
